spi_sequencer: RTL and testbench
================================

# spi_sequencer

Command-queue front end for the SPI master. It accepts 16-bit SPI words from the system side through a valid/ready handshake and buffers them in a small FIFO. It issues each word to the SPI master as a one-cycle load pulse, tracks completion through the SPI chip-select line, and returns read data through a valid/ready response port. It sits directly upstream of the SPI master, on the same divided clock, and replaces ad-hoc load/CSX polling in top-level designs.

## Interface
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- TIMEOUT, 64: max clk cycles spent in each SPI wait state before abort; ≥2.
- clk  in  1  system clock (same clock as SPI master); all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_data  in  17  {rd, word[15:0]}; rd=1 means capture a response.
- rsp_valid  out  1  response word held.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  16  SPI received word.
- spi_load  out  1  one-cycle start pulse to SPI master.
- spi_in  out  16  word to transmit; stable from load until the command completes.
- spi_out  in  16  SPI master received word.
- spi_csx  in  1  SPI chip select; 1 = idle, 0 = transfer in progress.
- busy  out  1  state != IDLE or FIFO non-empty.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.
- xfer_count  out  8  completed transfers, wraps 255→0.

## Operation
- Command FIFO: DEPTH entries, each holding the 17-bit cmd_data. Push on cmd_valid && cmd_ready. Pop only in IDLE.
  - A push and a pop in the same cycle are allowed when not full; count is unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE, RESP.
- IDLE: if FIFO non-empty, pop the head, register spi_in=word and rd_q=rd, then go to LOAD.
- LOAD: spi_load=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_START.
- WAIT_START: wait for spi_csx==0, then go to WAIT_DONE and clear the counter.
- WAIT_DONE: wait for spi_csx==1. On that cycle:
  - xfer_count increments.
  - If rd_q=1: latch rsp_data=spi_out and go to RESP.
  - Otherwise go to IDLE.
- RESP: rsp_valid=1 and rsp_data is held stable. On rsp_ready, go to IDLE. There is no response buffering, so a stalled consumer stalls the queue; the FIFO still accepts commands until full.
- Timeout: a counter runs in WAIT_START and WAIT_DONE. When the counter reaches TIMEOUT-1 without the awaited edge:
  - Set err and go to IDLE.
  - The command is dropped: no response, no xfer_count increment.
- err: set by timeout, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state is discarded, including FIFO contents and a pending response. spi_load cannot glitch high on the reset cycle.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
  - spi_load=0, spi_in=0.
  - busy=0, err=0, xfer_count=0.
  - FSM=IDLE, FIFO empty, timeout counter=0.
- All outputs are registered, except that cmd_ready and busy are decoded from registered state.
- Latency from a push at cycle N into an empty FIFO in IDLE:
  - Pop and spi_in update at edge N+1.
  - spi_load=1 during cycle N+2.
- Completion: spi_csx sampled high in WAIT_DONE at edge M gives rsp_valid=1 from M+1.
- Back-to-back commands: the minimum gap between spi_load pulses is LOAD + ≥1 WAIT_START + ≥1 WAIT_DONE + IDLE, i.e. 4 cycles plus SPI duration.
- spi_csx already low during LOAD is only acted on in WAIT_START, in the next cycle; no edge is lost.

## Test plan
- Reset/idle: rst_n=0 for 2 cycles, then release → all outputs at reset values, cmd_ready=1, no spi_load for 20 cycles.
- Read transfer: push {1,16'h0103}, SPI model drives csx low 3 cycles later, holds it 16 cycles, returns 16'hA5C3 → exactly one spi_load with spi_in=16'h0103, rsp_valid with rsp_data=16'hA5C3, xfer_count=1.
- Queue/backpressure: with DEPTH=4 and rsp_ready=0, push 6 read commands → cmd_ready drops after 4 are buffered plus 1 in flight. Release rsp_ready → 5 responses in order, then the 6th is accepted.
- Write-only: push {0,16'h0200} ×3 → 3 load pulses, no rsp_valid, xfer_count=3.
- Timeout: push a command and keep spi_csx=1 → after TIMEOUT cycles in WAIT_START, err=1, FSM in IDLE, xfer_count unchanged. err_clr clears it. Repeat with csx stuck at 0 (timeout in WAIT_DONE).
- Reset mid-transfer: assert rst_n=0 during WAIT_DONE with 2 queued commands → FIFO empties, no rsp_valid, no further spi_load after release.

Source files
------------

// File: rtl/spi_sequencer_if.sv
// rtl/spi_sequencer_if.sv - command/response handshake bundle for spi_sequencer
interface spi_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [16:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_sequencer.sv
// rtl/spi_sequencer.sv - command FIFO and load/CSX sequencer in front of the SPI master
module spi_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_sequencer_if.slave        cmd_if,
  output logic                  spi_load,
  output logic [15:0]           spi_in,
  input  logic [15:0]           spi_out,
  input  logic                  spi_csx,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [7:0]            xfer_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] spi_in_q, spi_in_d;
  logic        rd_q, rd_d;
  logic        spi_load_q, spi_load_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  xfer_q, xfer_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  logic        full, empty, push, pop, timeout, cnt_expired;
  logic [16:0] head;

  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    push        = cmd_if.cmd_valid && !full;
    pop         = (state_q == S_IDLE) && !empty;
    head        = mem_q[rd_ptr_q];
    cnt_expired = (cnt_q == TW'(TIMEOUT - 1));

    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    spi_in_d    = spi_in_q;
    rd_d        = rd_q;
    spi_load_d  = 1'b0;
    cnt_d       = cnt_q;
    xfer_d      = xfer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    timeout     = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // spi_load is registered so it is high exactly while the FSM sits in LOAD
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          spi_in_d   = head[15:0];
          rd_d       = head[16];
          spi_load_d = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!spi_csx) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_expired) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (spi_csx) begin
          xfer_d = xfer_q + 8'd1;
          if (rd_q) begin
            rsp_data_d  = spi_out;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_expired) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RESP: begin
        if (cmd_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a timeout in the same cycle as err_clr keeps the flag set
    err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      spi_in_q    <= '0;
      rd_q        <= 1'b0;
      spi_load_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      xfer_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      spi_in_q    <= spi_in_d;
      rd_q        <= rd_d;
      spi_load_q  <= spi_load_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      xfer_q      <= xfer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_if.cmd_data;
    end
  end

  assign cmd_if.cmd_ready = !full;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign spi_load         = spi_load_q;
  assign spi_in           = spi_in_q;
  assign busy             = (state_q != S_IDLE) || !empty;
  assign err              = err_q;
  assign xfer_count       = xfer_q;

endmodule

// File: tb/tb_spi_sequencer.sv
// tb/tb_spi_sequencer.sv - directed vector bench for spi_sequencer with a simple SPI slave model
module tb_spi_sequencer;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        spi_load;
  logic [15:0] spi_in;
  logic [15:0] spi_out;
  logic        spi_csx;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [7:0]  xfer_count;

  spi_sequencer_if bus ();

  spi_sequencer #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_if     (bus),
    .spi_load   (spi_load),
    .spi_in     (spi_in),
    .spi_out    (spi_out),
    .spi_csx    (spi_csx),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .xfer_count (xfer_count)
  );

  typedef struct {
    logic        rd;
    logic [15:0] word;
    int          start_dly;
    int          hold;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t        vecs [5];
  int          tests = 0;
  int          fails = 0;
  int          load_cnt = 0;
  logic [15:0] last_load = '0;
  logic [15:0] rsp_q [$];
  int          mode = 0;
  int          start_dly = 2;
  int          hold = 4;
  logic [15:0] model_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SPI slave: mode 0 = normal transfer, 1 = csx stuck high, 2 = csx stuck low after load
  initial begin
    spi_csx = 1'b1;
    spi_out = '0;
    forever begin
      @(negedge clk);
      if (spi_load === 1'b1 && mode == 0) begin
        model_cap = spi_in;
        repeat (start_dly) @(negedge clk);
        spi_csx = 1'b0;
        repeat (hold) @(negedge clk);
        spi_out = model_cap ^ 16'hA4C0;
        spi_csx = 1'b1;
        if (busy) check("spi_in_stable", {16'h0, spi_in}, {16'h0, model_cap});
      end else if (spi_load === 1'b1 && mode == 2) begin
        spi_csx = 1'b0;
      end else if (mode != 2) begin
        spi_csx = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spi_load === 1'b1) begin
        load_cnt++;
        last_load = spi_in;
      end
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) rsp_q.push_back(bus.rsp_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [16:0] d);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    step();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      step();
      n++;
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    check("idle_reached", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 500);
    check("rsp_valid_seen", {31'h0, bus.rsp_valid}, 32'h1);
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (spi_load !== 1'b1 && n < 50);
    check("load_seen", {31'h0, spi_load}, 32'h1);
  endtask

  initial begin
    int   l0, x0, r0, idx;
    logic acc;

    vecs[0] = '{1'b1, 16'h0103, 3, 16, 16'hA5C3};
    vecs[1] = '{1'b0, 16'h0200, 2, 4,  16'h0000};
    vecs[2] = '{1'b1, 16'hFFFF, 0, 2,  16'h5B3F};
    vecs[3] = '{1'b1, 16'h1234, 1, 8,  16'hB6F4};
    vecs[4] = '{1'b1, 16'h0000, 5, 1,  16'hA4C0};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
    check("rst_spi_load", {31'h0, spi_load}, 32'h0);
    check("rst_spi_in", {16'h0, spi_in}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_xfer", {24'h0, xfer_count}, 32'h0);
    l0 = load_cnt;
    repeat (20) @(negedge clk);
    check("idle_no_load", load_cnt, l0);

    for (int i = 0; i < 5; i++) begin
      start_dly = vecs[i].start_dly;
      hold      = vecs[i].hold;
      l0 = load_cnt;
      x0 = int'(xfer_count);
      r0 = rsp_q.size();
      push({vecs[i].rd, vecs[i].word});
      if (vecs[i].rd) begin
        wait_rsp();
        check("vec_rsp_data", {16'h0, bus.rsp_data}, {16'h0, vecs[i].exp_rsp});
        step();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
      end
      wait_idle();
      check("vec_load_count", load_cnt, l0 + 1);
      check("vec_spi_in", {16'h0, last_load}, {16'h0, vecs[i].word});
      check("vec_xfer", {24'h0, xfer_count}, (x0 + 1) & 32'hFF);
      check("vec_rsp_count", rsp_q.size(), r0 + int'(vecs[i].rd));
      check("vec_err", {31'h0, err}, 32'h0);
    end

    // write-only burst
    start_dly = 1;
    hold = 2;
    l0 = load_cnt;
    x0 = int'(xfer_count);
    r0 = rsp_q.size();
    repeat (3) push({1'b0, 16'h0200});
    wait_idle();
    repeat (2) @(negedge clk);
    check("wr3_loads", load_cnt, l0 + 3);
    check("wr3_xfer", {24'h0, xfer_count}, (x0 + 3) & 32'hFF);
    check("wr3_no_rsp", rsp_q.size(), r0);
    check("wr3_no_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // backpressure: stalled response port, 6 reads offered
    start_dly = 2;
    hold = 3;
    r0 = rsp_q.size();
    idx = 0;
    step();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {1'b1, 16'h0010};
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      acc = bus.cmd_ready && bus.cmd_valid;
      step();
      if (acc) begin
        idx++;
        bus.cmd_data = {1'b1, 16'h0010 + 16'(idx)};
        if (idx == 6) bus.cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", idx, 5);
    check("bp_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("bp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check("bp_rsp_head", {16'h0, bus.rsp_data}, 32'hA4D0);
    step();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 600 && (idx < 6 || rsp_q.size() < r0 + 6); c++) begin
      @(negedge clk);
      acc = bus.cmd_ready && bus.cmd_valid;
      step();
      if (acc) begin
        idx++;
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("bp_sixth_accepted", idx, 6);
    check("bp_rsp_total", rsp_q.size(), r0 + 6);
    for (int k = 0; k < 6; k++) begin
      if (r0 + k < rsp_q.size())
        check("bp_rsp_order", {16'h0, rsp_q[r0 + k]}, {16'h0, 16'hA4D0 | 16'(k)});
    end
    wait_idle();

    // timeout in WAIT_START
    mode = 1;
    x0 = int'(xfer_count);
    l0 = load_cnt;
    push({1'b0, 16'h0300});
    wait_load();
    repeat (TO) @(negedge clk);
    check("to_start_err_early", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("to_start_err", {31'h0, err}, 32'h1);
    check("to_start_idle", {31'h0, busy}, 32'h0);
    check("to_start_xfer", {24'h0, xfer_count}, x0 & 32'hFF);
    check("to_start_loads", load_cnt, l0 + 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", {31'h0, err}, 32'h0);

    // timeout in WAIT_DONE with err_clr held: set wins, then clears
    mode = 2;
    err_clr = 1'b1;
    push({1'b1, 16'h0301});
    wait_load();
    repeat (TO + 1) @(negedge clk);
    check("to_done_err_early", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("to_done_set_wins", {31'h0, err}, 32'h1);
    check("to_done_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    check("to_done_xfer", {24'h0, xfer_count}, x0 & 32'hFF);
    @(negedge clk);
    check("to_done_clr", {31'h0, err}, 32'h0);
    step();
    err_clr = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);

    // reset during WAIT_DONE with two commands queued
    start_dly = 2;
    hold = 30;
    r0 = rsp_q.size();
    push({1'b1, 16'h0400});
    push({1'b1, 16'h0401});
    push({1'b1, 16'h0402});
    repeat (6) @(negedge clk);
    check("mid_busy", {31'h0, busy}, 32'h1);
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    l0 = load_cnt;
    @(negedge clk);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("mid_rst_spi_in", {16'h0, spi_in}, 32'h0);
    check("mid_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("mid_rst_xfer", {24'h0, xfer_count}, 32'h0);
    repeat (60) @(negedge clk);
    check("mid_rst_no_load", load_cnt, l0);
    check("mid_rst_no_rsp", rsp_q.size(), r0);
    check("mid_rst_idle", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
